fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : Instruction fetch stage of a 5-stage pipeline. Holds the PC,  |
// |            presents it to instruction memory, and captures the fetched   |
// |            word into the IF/ID pipeline register. Honors hazard-unit     |
// |            stalls, squashes and branch redirects, and counts front-end   |
// |            stall cycles in a saturating counter.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk              in   1      clock, rising edge                        |
// |   rst              in   1      synchronous active-high reset             |
// |   PCWrite          in   1      PC enable (0 holds PC)                    |
// |   IF_ID_Write      in   1      IF/ID enable (0 holds IF/ID)              |
// |   IF_Flush         in   1      squash IF/ID                              |
// |   Branch_Taken     in   1      redirect request                          |
// |   Branch_Target    in   32     redirect address (word aligned on use)    |
// |   imem_addr        out  32     instruction memory address (= PC)         |
// |   imem_rdata       in   32     instruction word at imem_addr             |
// |   IF_ID_Instr      out  32     registered instruction                    |
// |   IF_ID_PC_plus4   out  32     registered PC+4 of that instruction       |
// |   IF_ID_Valid      out  1      IF_ID_Instr holds a real fetched word     |
// |   IF_ID_RegisterRs out  5      IF_ID_Instr[25:21]                        |
// |   IF_ID_RegisterRt out  5      IF_ID_Instr[20:16]                        |
// |   stall_cycles     out  CNT_W  saturating count of stalled cycles        |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             IF_Flush,
  input  logic             Branch_Taken,
  input  logic [31:0]      Branch_Target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PC_plus4,
  output logic             IF_ID_Valid,
  output logic [4:0]       IF_ID_RegisterRs,
  output logic [4:0]       IF_ID_RegisterRt,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [31:0] c_NOP        = 32'h0000_0000;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             squash;
  logic             stalled;

  // 32-bit add; the carry out is simply discarded so the PC wraps to 0.
  assign pc_plus4 = pc_q + 32'd4;

  // A redirect invalidates whatever was just fetched on the wrong path.
  assign squash  = IF_Flush | Branch_Taken;

  // Only a full front-end freeze counts as a stall; a redirect is progress.
  assign stalled = ~PCWrite & ~IF_ID_Write & ~Branch_Taken;

  // Next PC: redirect beats the hazard-unit enable, so a taken branch
  // escapes a load-use stall.
  always_comb begin
    pc_d = pc_q;
    if (Branch_Taken) begin
      pc_d = Branch_Target & c_ALIGN_MASK;
    end else if (PCWrite) begin
      pc_d = pc_plus4;
    end
  end

  // Next IF/ID contents: squash beats load beats hold.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (squash) begin
      instr_d = c_NOP;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (IF_ID_Write) begin
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Saturating stall counter: pins at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (stalled && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= c_NOP;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  // Memory address comes straight from the PC flop; no input reaches it
  // combinationally, which keeps the memory-read path out of the hazard logic.
  assign imem_addr        = pc_q;
  assign IF_ID_Instr      = instr_q;
  assign IF_ID_PC_plus4   = pc4_q;
  assign IF_ID_Valid      = valid_q;
  assign IF_ID_RegisterRs = instr_q[25:21];
  assign IF_ID_RegisterRt = instr_q[20:16];
  assign stall_cycles     = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                |
// | Purpose  : Self-checking bench for fetch_stage (CNT_W = 4). A table of   |
// |            stimulus/expected-state records plus hand sequences; expected |
// |            values are queued at drive time and popped after the edge.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam int          c_CNT_W    = 4;
  localparam logic [31:0] c_MASK     = 32'hA5A5_0000;

  logic              clk;
  logic              rst;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              IF_Flush;
  logic              Branch_Taken;
  logic [31:0]       Branch_Target;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       IF_ID_Instr;
  logic [31:0]       IF_ID_PC_plus4;
  logic              IF_ID_Valid;
  logic [4:0]        IF_ID_RegisterRs;
  logic [4:0]        IF_ID_RegisterRt;
  logic [c_CNT_W-1:0] stall_cycles;

  fetch_stage #(
    .RESET_PC (c_RESET_PC),
    .CNT_W    (c_CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .IF_Flush         (IF_Flush),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .IF_ID_Instr      (IF_ID_Instr),
    .IF_ID_PC_plus4   (IF_ID_PC_plus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .stall_cycles     (stall_cycles)
  );

  // Instruction memory model: word = address ^ A5A5_0000.
  assign imem_rdata = imem_addr ^ c_MASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [3:0]  e_stall;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ c_MASK;
  endfunction

  function automatic vec_t mk(input logic r, input logic pcw, input logic ifw,
                              input logic fl, input logic bt, input logic [31:0] tgt,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v, input logic [3:0] st);
    vec_t t;
    t.rst = r; t.pcw = pcw; t.ifw = ifw; t.flush = fl; t.bt = bt; t.tgt = tgt;
    t.e_pc = pc; t.e_instr = ins; t.e_pc4 = p4; t.e_valid = v; t.e_stall = st;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected post-edge state, then
  // pop and compare on the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst           = v.rst;
    PCWrite       = v.pcw;
    IF_ID_Write   = v.ifw;
    IF_Flush      = v.flush;
    Branch_Taken  = v.bt;
    Branch_Target = v.tgt;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,        e.e_pc);
      chk("instr",       IF_ID_Instr,      e.e_instr);
      chk("pc_plus4",    IF_ID_PC_plus4,   e.e_pc4);
      chk("valid",       {31'd0, IF_ID_Valid}, {31'd0, e.e_valid});
      chk("stall",       {28'd0, stall_cycles}, {28'd0, e.e_stall});
      chk("rs",          {27'd0, IF_ID_RegisterRs}, {27'd0, e.e_instr[25:21]});
      chk("rt",          {27'd0, IF_ID_RegisterRt}, {27'd0, e.e_instr[20:16]});
    end
  endtask

  vec_t tbl[20];

  initial begin
    //            rst pcw ifw fl bt  tgt           pc            instr             pc4           v  st
    tbl[0]  = mk(1, 1, 1, 1, 1, 32'h40,        32'h0,        32'h0,            32'h0,        0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 32'h0,         32'h4,        w(32'h0),         32'h4,        1, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 32'h0,         32'h8,        w(32'h4),         32'h8,        1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h8,        w(32'h4),         32'h8,        1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h8,        w(32'h4),         32'h8,        1, 2);
    tbl[5]  = mk(0, 1, 1, 0, 0, 32'h0,         32'hC,        w(32'h8),         32'hC,        1, 2);
    tbl[6]  = mk(0, 1, 1, 0, 0, 32'h0,         32'h10,       w(32'hC),         32'h10,       1, 2);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h103,       32'h100,      32'h0,            32'h0,        0, 2);
    tbl[8]  = mk(0, 1, 1, 0, 0, 32'h0,         32'h104,      w(32'h100),       32'h104,      1, 2);
    tbl[9]  = mk(0, 1, 1, 0, 1, 32'h20,        32'h20,       32'h0,            32'h0,        0, 2);
    tbl[10] = mk(0, 1, 1, 1, 0, 32'h0,         32'h24,       32'h0,            32'h0,        0, 2);
    tbl[11] = mk(0, 1, 1, 0, 0, 32'h0,         32'h28,       w(32'h24),        32'h28,       1, 2);
    tbl[12] = mk(0, 1, 0, 0, 0, 32'h0,         32'h2C,       w(32'h24),        32'h28,       1, 2);
    tbl[13] = mk(0, 1, 1, 0, 0, 32'h0,         32'h30,       w(32'h2C),        32'h30,       1, 2);
    tbl[14] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,           32'h0,        0, 2);
    tbl[15] = mk(0, 1, 1, 0, 0, 32'h0,         32'h0,        w(32'hFFFF_FFFC), 32'h0,        1, 2);
    tbl[16] = mk(1, 1, 1, 1, 1, 32'h40,        c_RESET_PC,   32'h0,            32'h0,        0, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 32'h0,         32'h4,        w(32'h0),         32'h4,        1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 32'h0,         32'h4,        w(32'h0),         32'h4,        1, 1);
    tbl[19] = mk(0, 0, 1, 0, 0, 32'h0,         32'h4,        w(32'h4),         32'h8,        1, 1);

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i]);
    end

    // Saturation: 20 consecutive stalls on a 4-bit counter pin at 15.
    apply(mk(1, 0, 0, 0, 0, 32'h0, c_RESET_PC, 32'h0, 32'h0, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      apply(mk(0, 0, 0, 0, 0, 32'h0, c_RESET_PC, 32'h0, 32'h0, 0,
               (i > 15) ? 4'd15 : 4'(i)));
    end

    // Reset during a stall with a simultaneous redirect, then clean restart.
    apply(mk(1, 0, 0, 0, 0, 32'h0, c_RESET_PC, 32'h0, 32'h0, 0, 0));
    apply(mk(0, 1, 1, 0, 0, 32'h0, 32'h4, w(32'h0), 32'h4, 1, 0));
    for (int i = 1; i <= 3; i++) begin
      apply(mk(0, 0, 0, 0, 0, 32'h0, 32'h4, w(32'h0), 32'h4, 1, 4'(i)));
    end
    apply(mk(1, 0, 0, 1, 1, 32'h200, c_RESET_PC, 32'h0, 32'h0, 0, 0));
    apply(mk(0, 1, 1, 0, 0, 32'h0, 32'h4, w(c_RESET_PC), 32'h4, 1, 0));
    apply(mk(0, 1, 1, 0, 0, 32'h0, 32'h8, w(32'h4), 32'h8, 1, 0));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
